prog_loader: RTL
================

// Module: prog_loader
// PURPOSE
//  Write side of the program ROM: receives a byte stream, packs it into DATA_WIDTH
//  words and drives single-cycle writes into the program memory array.
//  Sits between a byte source (UART/debug port) and the memory; fills the image
//  at boot in place of a fixed program.hex.
// PARAMETERS
//  ADDR_WIDTH  16  word-address width of target memory (depth = 2**ADDR_WIDTH)
//  DATA_WIDTH  32  memory word width; must be a multiple of 8 (BPW = DATA_WIDTH/8)
//  BASE_ADDR   0   word address of the first written word
// PORTS
//  clk          in   1           system clock, all logic on rising edge
//  rst          in   1           synchronous, active-high reset
//  start        in   1           begin a load; sampled only in IDLE
//  in_data      in   8           stream byte
//  in_valid     in   1           in_data valid
//  in_ready     out  1           byte accepted when in_valid & in_ready
//  mem_we       out  1           write strobe, one cycle per word
//  mem_addr     out  ADDR_WIDTH  write word address
//  mem_wdata    out  DATA_WIDTH  write data
//  busy         out  1           load in progress
//  done         out  1           one-cycle pulse at end of load
//  err          out  1           sticky error, cleared by next accepted start
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, byte/word counters 0, partial word discarded.
//  - States: IDLE -> LEN_LO -> LEN_HI -> DATA [-> CSUM] -> DONE -> IDLE.
//  - IDLE: in_ready=0; start=1 -> LEN_LO next cycle, busy=1, err cleared.
//    start in any other state ignored.
//  - in_ready=1 in LEN_LO, LEN_HI, DATA, CSUM; no backpressure otherwise.
//  - LEN_LO/LEN_HI: 16-bit word count N, low byte first.
//    N==0 -> DONE, no writes.
//    N > 2**ADDR_WIDTH -> err=1 -> DONE, no writes.
//  - DATA: bytes little-endian within a word (first byte -> bits [7:0]).
//    On the handshake of byte BPW-1 of word k, the next cycle has mem_we=1,
//    mem_addr=BASE_ADDR+k (mod 2**ADDR_WIDTH), and mem_wdata=the assembled word.
//    Write latency: exactly 1 cycle after the final byte handshake.
//    mem_addr/mem_wdata hold their value when mem_we=0.
//  - After word N-1 is accepted: -> CSUM (if enabled) else -> DONE.
//    The write of word N-1 coincides with the first cycle of the next state.
//  - DONE: done=1 for one cycle, busy falls the same cycle, -> IDLE.
//  - in_valid=0 gaps of any length stall the FSM; no timeout.
//  - rst mid-load: immediate abort; words already written stay written;
//    the partial word is never written.
// CONFIGURATION
//  LOADER_CHECKSUM_EN defined:
//    - After the data bytes, one extra byte equal to the XOR of all data bytes.
//    - Mismatch -> err=1 at DONE; written words are not rolled back.
//  LOADER_CHECKSUM_EN undefined:
//    - No CSUM state; DATA -> DONE directly; err set only by an oversize N.
// TESTING
//  1 rst=1 for 2 cycles -> in_ready=0, mem_we=0, busy=0, done=0, err=0.
//  2 start, then bytes 02 00 | 78 56 34 12 | EF BE AD DE (BASE_ADDR=0)
//    -> mem_we pulses: addr 0 data 0x12345678, then addr 1 data 0xDEADBEEF;
//       done pulses once.
//  3 start, N=0 (00 00) -> done pulses within 1 cycle of the LEN_HI byte;
//    no mem_we; err=0.
//  4 ADDR_WIDTH=4, N=17 (11 00) -> err=1, done pulses, no mem_we;
//    next start clears err.
//  5 rst asserted after 2 of 4 bytes of word 1 (N=2) -> no write for word 1;
//    state IDLE; busy=0.
//  6 LOADER_CHECKSUM_EN, N=1, data 01 02 03 04, csum 04 -> err=0;
//    csum 05 -> err=1, word still written.
//  Also: random in_valid gaps must give identical writes; start while busy
//  must be ignored.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: byte-stream program loader; packs bytes into words and writes them to program memory.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             begin a load (honoured only when idle)
//   in_data/in_valid  byte stream in; in_ready = byte accepted
//   mem_we/mem_addr/mem_wdata  single-cycle word write
//   busy, done, err   load in progress, end-of-load pulse, sticky error
module prog_loader #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [7:0]            in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int BPW = DATA_WIDTH / 8;
   localparam int IW  = (BPW > 1) ? $clog2(BPW) : 1;
   localparam logic [IW-1:0] LAST_BYTE = IW'(BPW - 1);
   localparam logic [32:0]   DEPTH     = 33'(1) << ADDR_WIDTH;

`ifdef LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {
      S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_DONE
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_DONE
   } state_t;
`endif

   state_t state, state_nxt;

   logic [7:0]            len_lo;
   logic [15:0]           len;
   logic [15:0]           word_cnt;
   logic [IW-1:0]         byte_idx;
   logic [DATA_WIDTH-1:0] word_buf;
   logic [DATA_WIDTH-1:0] word_asm;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [15:0]           len_in;
   logic                  hs;
   logic                  oversize;
   logic                  last_byte;
   logic                  last_word;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]            csum;
`endif

   assign hs        = in_valid & in_ready;
   assign len_in    = {in_data, len_lo};
   assign oversize  = 33'(len_in) > DEPTH;
   assign last_byte = byte_idx == LAST_BYTE;
   assign last_word = word_cnt == (len - 16'd1);

   // Current partial word with the incoming byte merged in at its lane.
   always_comb begin
      word_asm = word_buf;
      word_asm[{byte_idx, 3'b000} +: 8] = in_data;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (start) state_nxt = S_LEN_LO;
         end
         S_LEN_LO: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (in_valid) state_nxt = S_LEN_HI;
         end
         S_LEN_HI: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (in_valid) begin
               if (len_in == 16'd0 || oversize) state_nxt = S_DONE;
               else                             state_nxt = S_DATA;
            end
         end
         S_DATA: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (in_valid && last_byte && last_word) begin
`ifdef LOADER_CHECKSUM_EN
               state_nxt = S_CSUM;
`else
               state_nxt = S_DONE;
`endif
            end
         end
`ifdef LOADER_CHECKSUM_EN
         S_CSUM: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (in_valid) state_nxt = S_DONE;
         end
`endif
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         len_lo    <= '0;
         len       <= '0;
         word_cnt  <= '0;
         byte_idx  <= '0;
         word_buf  <= '0;
         wr_addr   <= BASE_ADDR;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         err       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         csum      <= '0;
`endif
      end else begin
         mem_we <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  err      <= 1'b0;
                  word_cnt <= '0;
                  byte_idx <= '0;
                  word_buf <= '0;
                  wr_addr  <= BASE_ADDR;
`ifdef LOADER_CHECKSUM_EN
                  csum     <= '0;
`endif
               end
            end
            S_LEN_LO: begin
               if (hs) len_lo <= in_data;
            end
            S_LEN_HI: begin
               if (hs) begin
                  len <= len_in;
                  if (oversize) err <= 1'b1;
               end
            end
            S_DATA: begin
               if (hs) begin
                  word_buf <= word_asm;
`ifdef LOADER_CHECKSUM_EN
                  csum     <= csum ^ in_data;
`endif
                  if (last_byte) begin
                     mem_we    <= 1'b1;
                     mem_addr  <= wr_addr;
                     mem_wdata <= word_asm;
                     wr_addr   <= wr_addr + 1'b1;
                     word_cnt  <= word_cnt + 16'd1;
                     byte_idx  <= '0;
                  end else begin
                     byte_idx <= byte_idx + 1'b1;
                  end
               end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
               if (hs && in_data != csum) err <= 1'b1;
            end
`endif
            default: ;
         endcase
      end
   end

endmodule
